quarter_sin_ram: RTL and testbench



---
 rtl/quarter_sin_ram.sv | 156 +++++++++++++++
 tb/tb_quarter_sin_ram.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quarter_sin_ram.sv
// quarter_sin_ram
// Sine/cosine lookup for the mixer. A quarter-wave magnitude table is held in
// a RAM with one write port and two read paths. Full-cycle signed sin and cos
// are rebuilt from quadrant symmetry. The pipeline streams one phase per clock.
//
// Parameters
//   PHASE_W   : full-cycle phase width, 2^PHASE_W points per cycle (>= 3)
//   RAM_WIDTH : signed output width; table entries are RAM_WIDTH-1 bits
//   OUT_REG   : 1 adds an output register stage
//   INIT_FILE : hex image for the quarter table, "" leaves it unloaded
//
// Ports
//   clk        : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (table contents are kept)
//   i_wr_en    : table write enable
//   i_wr_addr  : table write address
//   i_wr_data  : unsigned magnitude to write
//   i_valid    : phase sample valid
//   i_phase    : phase index
//   o_valid    : output sample valid, 2+OUT_REG cycles after i_valid
//   o_sin      : signed sin of (phase+0.5)
//   o_cos      : signed cos of (phase+0.5)
module quarter_sin_ram #(
    parameter int    PHASE_W   = 7,
    parameter int    RAM_WIDTH = 8,
    parameter bit    OUT_REG   = 1'b1,
    parameter string INIT_FILE = ""
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_en,
    input  logic [PHASE_W-3:0]          i_wr_addr,
    input  logic [RAM_WIDTH-2:0]        i_wr_data,
    input  logic                        i_valid,
    input  logic [PHASE_W-1:0]          i_phase,
    output logic                        o_valid,
    output logic signed [RAM_WIDTH-1:0] o_sin,
    output logic signed [RAM_WIDTH-1:0] o_cos
);

    localparam int K_W = PHASE_W - 2;
    localparam int Q   = 1 << K_W;

    logic [RAM_WIDTH-2:0] mem [Q];

    initial begin
        for (int i = 0; i < Q; i++) begin
            mem[i] = '0;
        end
    end

    // Reads in the same edge see the old contents (read-first).
    always @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Quadrant decode. Cos is sin advanced by one quadrant, so its mirror
    // and sign rules are the sin rules applied to quad+1.
    logic [1:0]     quad;
    logic [K_W-1:0] k;
    logic [K_W-1:0] sin_addr;
    logic [K_W-1:0] cos_addr;
    logic           sin_neg;
    logic           cos_neg;

    assign quad     = i_phase[PHASE_W-1 -: 2];
    assign k        = i_phase[K_W-1:0];
    assign sin_addr = quad[0] ? ~k : k;
    assign cos_addr = quad[0] ? k : ~k;
    assign sin_neg  = quad[1];
    assign cos_neg  = quad[1] ^ quad[0];

    // Stage 1: registered RAM reads. Data registers carry no reset so the
    // read path can map onto block RAM output registers.
    logic                 v1;
    logic [RAM_WIDTH-2:0] mag_s1;
    logic [RAM_WIDTH-2:0] mag_c1;
    logic                 neg_s1;
    logic                 neg_c1;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0;
        end else begin
            v1 <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            mag_s1 <= mem[sin_addr];
            mag_c1 <= mem[cos_addr];
            neg_s1 <= sin_neg;
            neg_c1 <= cos_neg;
        end
    end

    // Stage 2: apply sign. Magnitudes never exceed 2^(RAM_WIDTH-1)-1, so
    // the negation cannot overflow.
    logic                        v2;
    logic signed [RAM_WIDTH-1:0] ext_s;
    logic signed [RAM_WIDTH-1:0] ext_c;
    logic signed [RAM_WIDTH-1:0] sin_s2;
    logic signed [RAM_WIDTH-1:0] cos_s2;

    assign ext_s = {1'b0, mag_s1};
    assign ext_c = {1'b0, mag_c1};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2     <= 1'b0;
            sin_s2 <= '0;
            cos_s2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sin_s2 <= neg_s1 ? -ext_s : ext_s;
                cos_s2 <= neg_c1 ? -ext_c : ext_c;
            end
        end
    end

    // Stage 3: optional output register.
    generate
        if (OUT_REG) begin : g_out_reg
            logic                        v3;
            logic signed [RAM_WIDTH-1:0] sin_s3;
            logic signed [RAM_WIDTH-1:0] cos_s3;

            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    v3     <= 1'b0;
                    sin_s3 <= '0;
                    cos_s3 <= '0;
                end else begin
                    v3 <= v2;
                    if (v2) begin
                        sin_s3 <= sin_s2;
                        cos_s3 <= cos_s2;
                    end
                end
            end

            assign o_valid = v3;
            assign o_sin   = sin_s3;
            assign o_cos   = cos_s3;
        end else begin : g_no_out_reg
            assign o_valid = v2;
            assign o_sin   = sin_s2;
            assign o_cos   = cos_s2;
        end
    endgenerate

endmodule

// File: tb/tb_quarter_sin_ram.sv
// Bench for quarter_sin_ram. Instance A: PHASE_W=7, OUT_REG=1 (sweep,
// collision, bubbles, reset). Instance B: PHASE_W=5, OUT_REG=0 (symmetry
// vectors and two-cycle latency). Expected samples are queued at issue time
// and popped by per-instance monitors on the falling edge.
module tb_quarter_sin_ram;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              a_wr_en;
    logic [4:0]        a_wr_addr;
    logic [6:0]        a_wr_data;
    logic              a_valid;
    logic [6:0]        a_phase;
    logic              a_ov;
    logic signed [7:0] a_sin;
    logic signed [7:0] a_cos;

    logic              b_wr_en;
    logic [2:0]        b_wr_addr;
    logic [6:0]        b_wr_data;
    logic              b_valid;
    logic [4:0]        b_phase;
    logic              b_ov;
    logic signed [7:0] b_sin;
    logic signed [7:0] b_cos;

    quarter_sin_ram #(.PHASE_W(7), .RAM_WIDTH(8), .OUT_REG(1'b1), .INIT_FILE("")) u_a (
        .clk(clk), .i_rst_n(rst_n), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr),
        .i_wr_data(a_wr_data), .i_valid(a_valid), .i_phase(a_phase),
        .o_valid(a_ov), .o_sin(a_sin), .o_cos(a_cos));

    quarter_sin_ram #(.PHASE_W(5), .RAM_WIDTH(8), .OUT_REG(1'b0), .INIT_FILE("")) u_b (
        .clk(clk), .i_rst_n(rst_n), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
        .i_wr_data(b_wr_data), .i_valid(b_valid), .i_phase(b_phase),
        .o_valid(b_ov), .o_sin(b_sin), .o_cos(b_cos));

    typedef struct {
        int s;
        int c;
        int t;
        int p;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   a_last_s = 0, a_last_c = 0, b_last_s = 0, b_last_c = 0;
    int   a_obs[128];
    int   tbl_a[32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    function automatic int msin(input int p);
        return rnd(127.0 * $sin(2.0 * PI * (p + 0.5) / 128.0));
    endfunction

    function automatic int mcos(input int p);
        return rnd(127.0 * $cos(2.0 * PI * (p + 0.5) / 128.0));
    endfunction

    // Monitors
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            if (a_ov) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_valid: got o_valid=1 expected no sample (t=%0t)", $time);
                end else begin
                    e = qa.pop_front();
                    chk("a_sin", a_sin, e.s);
                    chk("a_cos", a_cos, e.c);
                    chk("a_latency", cyc - e.t, 3);
                    a_last_s = e.s;
                    a_last_c = e.c;
                    if (e.p >= 0) a_obs[e.p] = a_sin;
                end
            end else begin
                chk("a_hold_sin", a_sin, a_last_s);
                chk("a_hold_cos", a_cos, a_last_c);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n) begin
            if (b_ov) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_valid: got o_valid=1 expected no sample (t=%0t)", $time);
                end else begin
                    e = qb.pop_front();
                    chk("b_sin", b_sin, e.s);
                    chk("b_cos", b_cos, e.c);
                    chk("b_latency", cyc - e.t, 2);
                    b_last_s = e.s;
                    b_last_c = e.c;
                end
            end else begin
                chk("b_hold_sin", b_sin, b_last_s);
                chk("b_hold_cos", b_cos, b_last_c);
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input int addr, input int data);
        a_wr_en   = 1'b1;
        a_wr_addr = 5'(addr);
        a_wr_data = 7'(data);
        step();
        a_wr_en = 1'b0;
        tbl_a[addr] = data;
    endtask

    task automatic b_write(input int addr, input int data);
        b_wr_en   = 1'b1;
        b_wr_addr = 3'(addr);
        b_wr_data = 7'(data);
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic a_issue(input int p, input int es, input int ec, input int rec);
        a_valid = 1'b1;
        a_phase = 7'(p);
        qa.push_back('{es, ec, cyc, rec});
        step();
        a_valid = 1'b0;
    endtask

    task automatic b_issue(input int p, input int es, input int ec);
        b_valid = 1'b1;
        b_phase = 5'(p);
        qb.push_back('{es, ec, cyc, -1});
        step();
        b_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_valid = 1'b0; a_phase = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_valid = 1'b0; b_phase = '0;
        repeat (3) step();
        chk("rst_a_valid", int'(a_ov), 0);
        chk("rst_a_sin", a_sin, 0);
        chk("rst_a_cos", a_cos, 0);
        chk("rst_b_valid", int'(b_ov), 0);
        chk("rst_b_sin", b_sin, 0);
        chk("rst_b_cos", b_cos, 0);
        rst_n = 1'b1;
        step();

        // Table loads
        for (int k = 0; k < 32; k++) a_write(k, msin(k));
        for (int k = 0; k < 8; k++) b_write(k, 0);
        b_write(0, 12);
        b_write(7, 127);

        // Quadrant symmetry, back-to-back (instance B)
        b_issue(0, 12, 127);
        b_issue(8, 127, -12);
        b_issue(16, -12, -127);
        b_issue(24, -127, 12);
        repeat (4) step();

        // Single pulse, two-cycle latency, width one (instance B)
        b_issue(0, 12, 127);
        repeat (4) step();

        // Full sweep with wrap (instance A)
        for (int p = 0; p < 128; p++) a_issue(p, msin(p), mcos(p), p);
        a_issue(0, msin(0), mcos(0), -1);
        repeat (5) step();
        for (int p = 0; p < 64; p++) chk("a_half_cycle_antisym", a_obs[p], -a_obs[p + 64]);

        // Read-first collision on mem[3]
        a_write(3, 'h10);
        a_wr_en   = 1'b1;
        a_wr_addr = 5'd3;
        a_wr_data = 7'h55;
        a_issue(3, 16, tbl_a[28], -1);
        a_wr_en = 1'b0;
        tbl_a[3] = 'h55;
        a_issue(3, 85, tbl_a[28], -1);
        a_write(3, msin(3));
        repeat (5) step();

        // Bubbles 1,0,0,1
        a_issue(5, msin(5), mcos(5), -1);
        repeat (2) step();
        a_issue(70, msin(70), mcos(70), -1);
        repeat (5) step();

        // Reset with samples in flight (not queued, must never appear)
        a_valid = 1'b1;
        a_phase = 7'd10;
        step();
        a_phase = 7'd11;
        step();
        a_phase = 7'd12;
        step();
        a_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        a_last_s = 0; a_last_c = 0; b_last_s = 0; b_last_c = 0;
        #1;
        chk("rst_mid_a_valid", int'(a_ov), 0);
        chk("rst_mid_a_sin", a_sin, 0);
        chk("rst_mid_a_cos", a_cos, 0);
        chk("rst_mid_b_sin", b_sin, 0);
        chk("rst_mid_b_cos", b_cos, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();

        // Table survives reset
        a_issue(0, msin(0), mcos(0), -1);
        b_issue(8, 127, -12);

        begin
            int n = 0;
            while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
                step();
                n++;
            end
            repeat (2) step();
            checks++;
            if (qa.size() != 0 || qb.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d/%0d samples outstanding expected 0/0", qa.size(), qb.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
